mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_iter.sv | 55 +++++
 rtl/mdu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: default width, op codes
// and controller state encoding.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_mul_step,
   input  logic             i_div_step,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;

   // Multiply keeps {acc,q} as the partial product shifted right each step;
   // divide shifts {acc,q} left and q collects quotient bits.
   assign w_sum   = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_b : '0)};
   assign w_shift = {r_acc, r_q[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_b});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_q   <= '0;
         r_b   <= '0;
      end else if (i_load) begin
         r_acc <= i_acc;
         r_q   <= i_q;
         r_b   <= i_b;
      end else if (i_mul_step) begin
         r_acc <= w_sum[WIDTH:1];
         r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      end else if (i_div_step) begin
         // Remainder stays below the divisor, so WIDTH-bit subtraction is exact.
         r_acc <= w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
         r_q   <= {r_q[WIDTH-2:0], w_ge};
      end
   end

   assign o_hi = r_acc;
   assign o_lo = r_q;

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide controller: sequences mdu_iter, applies sign
// pre/post-correction and generates the register-file write strobes.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             stall,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_i,
   output logic [WIDTH-1:0] lo_i,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_mul, r_neg_q, r_neg_r, r_mt_hi, r_mt_lo;
   logic               w_load, w_mul_step, w_div_step, w_mt_hi_nxt, w_mt_lo_nxt;
   logic               w_is_mul_nxt, w_neg_q_nxt, w_neg_r_nxt;
   logic               w_sgn, w_muldiv, w_last;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_acc_ld, w_q_ld, w_b_ld;
   logic [WIDTH-1:0]   w_it_hi, w_it_lo, w_hi_div, w_lo_div;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;

   assign w_sgn    = (op == OP_MULT) || (op == OP_DIV);
   assign w_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   assign w_a_mag  = (w_sgn && src1[WIDTH-1]) ? -src1 : src1;
   assign w_b_mag  = (w_sgn && src2[WIDTH-1]) ? -src2 : src2;
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_mul_step   = 1'b0;
      w_div_step   = 1'b0;
      w_mt_hi_nxt  = 1'b0;
      w_mt_lo_nxt  = 1'b0;
      w_acc_ld     = '0;
      w_q_ld       = '0;
      w_b_ld       = '0;
      w_is_mul_nxt = 1'b0;
      w_neg_q_nxt  = 1'b0;
      w_neg_r_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     w_load       = 1'b1;
                     w_q_ld       = w_a_mag;
                     w_b_ld       = w_b_mag;
                     w_is_mul_nxt = 1'b1;
                     w_neg_q_nxt  = w_sgn && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                     w_state_nxt  = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     w_load = 1'b1;
                     // Divide-by-zero result is preloaded so DONE can present it raw.
                     if (src2 == '0) begin
                        w_acc_ld    = src1;
                        w_q_ld      = '1;
                        w_state_nxt = S_DONE;
                     end else begin
                        w_q_ld      = w_a_mag;
                        w_b_ld      = w_b_mag;
                        w_neg_q_nxt = w_sgn && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                        w_neg_r_nxt = w_sgn && src1[WIDTH-1];
                        w_state_nxt = S_DIV;
                     end
                  end
                  OP_MTHI: begin
                     w_load      = 1'b1;
                     w_acc_ld    = src1;
                     w_mt_hi_nxt = 1'b1;
                  end
                  OP_MTLO: begin
                     w_load      = 1'b1;
                     w_q_ld      = src1;
                     w_mt_lo_nxt = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            w_mul_step = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DIV: begin
            w_div_step = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (cancel) begin
         w_state_nxt = S_IDLE;
         w_load      = 1'b0;
         w_mul_step  = 1'b0;
         w_div_step  = 1'b0;
         w_mt_hi_nxt = 1'b0;
         w_mt_lo_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_mul <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_mt_hi  <= 1'b0;
         r_mt_lo  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mt_hi <= w_mt_hi_nxt;
         r_mt_lo <= w_mt_lo_nxt;
         if (w_load) begin
            r_cnt    <= '0;
            r_is_mul <= w_is_mul_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
         end else if (w_mul_step || w_div_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   mdu_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_mul_step (w_mul_step),
      .i_div_step (w_div_step),
      .i_acc      (w_acc_ld),
      .i_q        (w_q_ld),
      .i_b        (w_b_ld),
      .o_hi       (w_it_hi),
      .o_lo       (w_it_lo)
   );

   assign w_prod     = {w_it_hi, w_it_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_lo_div   = r_neg_q ? -w_it_lo : w_it_lo;
   assign w_hi_div   = r_neg_r ? -w_it_hi : w_it_hi;

   always_comb begin
      hi_i = '0;
      lo_i = '0;
      if ((r_state == S_DONE) || r_mt_hi || r_mt_lo) begin
         if (r_is_mul) begin
            {hi_i, lo_i} = w_prod_fix;
         end else begin
            hi_i = w_hi_div;
            lo_i = w_lo_div;
         end
      end
   end

   assign hi_we = !cancel && ((r_state == S_DONE) || r_mt_hi);
   assign lo_we = !cancel && ((r_state == S_DONE) || r_mt_lo);
   assign stall = ((r_state == S_IDLE) && start && w_muldiv) ||
                  (r_state == S_MUL) || (r_state == S_DIV);
   assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed and random ops against an
// arithmetic reference model, plus cancel, reset and start-while-busy cases.
module tb_mdu_ctrl;

   localparam logic [2:0] T_MULT  = 3'd0;
   localparam logic [2:0] T_MULTU = 3'd1;
   localparam logic [2:0] T_DIV   = 3'd2;
   localparam logic [2:0] T_DIVU  = 3'd3;
   localparam logic [2:0] T_MTHI  = 3'd4;
   localparam logic [2:0] T_MTLO  = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        cancel = 1'b0;
   logic        stall, hi_we, lo_we, busy;
   logic [31:0] hi_i, lo_i;

   int n_checks = 0;
   int n_fail   = 0;

   mdu_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
      .cancel(cancel), .stall(stall), .hi_we(hi_we), .lo_we(lo_we),
      .hi_i(hi_i), .lo_i(lo_i), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eh = '0;
      el = '0;
      case (o)
         T_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
         T_MULTU: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
         T_DIV: begin
            if (b == 0) begin eh = a; el = '1; end
            else begin q = sa / sb; r = sa % sb; el = 32'(q); eh = 32'(r); end
         end
         T_DIVU: begin
            if (b == 0) begin eh = a; el = '1; end
            else begin el = a / b; eh = a % b; end
         end
         default: ;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
      logic [31:0] eh, el;
      int          exp_lat, lat, bad_stall;
      model(o, a, b, eh, el);
      exp_lat = ((o == T_DIV || o == T_DIVU) && b == 0) ? 1 : 33;
      @(posedge clk); #1;
      start = 1'b1; op = o; src1 = a; src2 = b;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL %s accept_stall got=%b exp=1", nm, stall); end
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bad_stall = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (hi_we || lo_we) begin lat = c; break; end
         if (stall !== 1'b1 || busy !== 1'b1) bad_stall++;
      end
      n_checks++;
      if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency got=%0d exp=%0d (0=timeout)", nm, lat, exp_lat); end
      if (lat != 0) begin
         n_checks++;
         if (bad_stall != 0) begin n_fail++; $display("FAIL %s busy_stall bad_cycles=%0d exp=0", nm, bad_stall); end
         n_checks++;
         if ({hi_we, lo_we, stall} !== 3'b110) begin
            n_fail++; $display("FAIL %s done_strobes got hi_we=%b lo_we=%b stall=%b exp 1 1 0", nm, hi_we, lo_we, stall);
         end
         n_checks++;
         if (hi_i !== eh || lo_i !== el) begin
            n_fail++; $display("FAIL %s result got hi=%h lo=%h exp hi=%h lo=%h", nm, hi_i, lo_i, eh, el);
         end
         @(negedge clk);
         n_checks++;
         if ({hi_we, lo_we, busy} !== 3'b000) begin
            n_fail++; $display("FAIL %s after_done got hi_we=%b lo_we=%b busy=%b exp 0 0 0", nm, hi_we, lo_we, busy);
         end
      end
   endtask

   task automatic test_reset;
      #2;
      n_checks++;
      if ({stall, busy, hi_we, lo_we} !== 4'b0000 || hi_i !== '0 || lo_i !== '0) begin
         n_fail++; $display("FAIL reset_outputs got stall=%b busy=%b hi_we=%b lo_we=%b hi=%h lo=%h exp all 0",
                            stall, busy, hi_we, lo_we, hi_i, lo_i);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_directed;
      run_op(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
      run_op(T_DIV,   32'hFFFFFFF9, 32'd2,        "div_m7_2");
      run_op(T_DIVU,  32'd5,        32'd0,        "divu_by0");
      run_op(T_DIV,   32'hFFFFFFF9, 32'd0,        "div_by0");
      run_op(T_MULT,  32'h80000000, 32'h80000000, "mult_minmin");
      run_op(T_DIV,   32'h80000000, 32'hFFFFFFFF, "div_min_m1");
      run_op(T_MULT,  32'hFFFFFFFD, 32'd7,        "mult_neg_pos");
      run_op(T_DIV,   32'd7,        32'hFFFFFFFE, "div_pos_neg");
   endtask

   task automatic test_random;
      logic [31:0] pick [6];
      logic [31:0] a, b;
      logic [2:0]  o;
      pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFFFFFF;
      pick[3] = 32'h80000000; pick[4] = 32'h7FFFFFFF; pick[5] = 32'd3;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
         run_op(o, a, b, $sformatf("rand%0d_op%0d", i, o));
      end
   endtask

   task automatic test_mt;
      logic [31:0] d;
      d = 32'h12345678;
      @(posedge clk); #1;
      start = 1'b1; op = T_MTHI; src1 = d; src2 = $urandom;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_accept_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({hi_we, lo_we, stall} !== 3'b100 || hi_i !== d) begin
         n_fail++; $display("FAIL mthi_write got hi_we=%b lo_we=%b stall=%b hi=%h exp 1 0 0 %h", hi_we, lo_we, stall, hi_i, d);
      end
      @(negedge clk);
      n_checks++;
      if ({hi_we, lo_we} !== 2'b00) begin n_fail++; $display("FAIL mthi_after got hi_we=%b lo_we=%b exp 0 0", hi_we, lo_we); end
      d = $urandom;
      @(posedge clk); #1;
      start = 1'b1; op = T_MTLO; src1 = d;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({hi_we, lo_we, stall} !== 3'b010 || lo_i !== d) begin
         n_fail++; $display("FAIL mtlo_write got hi_we=%b lo_we=%b stall=%b lo=%h exp 0 1 0 %h", hi_we, lo_we, stall, lo_i, d);
      end
      @(posedge clk); #1;
      start = 1'b1; op = T_MTLO; src1 = ~d;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({hi_we, lo_we} !== 2'b00) begin n_fail++; $display("FAIL mtlo_cancel got hi_we=%b lo_we=%b exp 0 0", hi_we, lo_we); end
      @(posedge clk); #1;
      cancel = 1'b0;
   endtask

   task automatic test_cancel;
      int strobes;
      strobes = 0;
      @(posedge clk); #1;
      start = 1'b1; op = T_MULT; src1 = $urandom; src2 = $urandom;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == 10) cancel = 1'b1;
         @(negedge clk);
         if (hi_we || lo_we) strobes++;
      end
      @(posedge clk); #1;
      cancel = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || stall !== 1'b0 || strobes != 0 || hi_we || lo_we) begin
         n_fail++; $display("FAIL cancel_idle got busy=%b stall=%b strobes=%0d exp 0 0 0", busy, stall, strobes);
      end
      run_op(T_MULTU, 32'hDEADBEEF, 32'h00C0FFEE, "after_cancel");
      @(posedge clk); #1;
      start = 1'b1; op = T_DIVU; src1 = 32'd100; src2 = 32'd7; cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_over_start got busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      int strobes;
      strobes = 0;
      @(posedge clk); #1;
      start = 1'b1; op = T_DIVU; src1 = $urandom; src2 = 32'd3;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({stall, busy, hi_we, lo_we} !== 4'b0000 || hi_i !== '0 || lo_i !== '0) begin
         n_fail++; $display("FAIL reset_mid got stall=%b busy=%b hi_we=%b lo_we=%b hi=%h lo=%h exp all 0",
                            stall, busy, hi_we, lo_we, hi_i, lo_i);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hi_we || lo_we || busy) strobes++;
      end
      n_checks++;
      if (strobes != 0) begin n_fail++; $display("FAIL reset_discard active_cycles=%0d exp=0", strobes); end
   endtask

   task automatic test_start_busy;
      logic [31:0] a, b, eh, el;
      int          lat;
      a = $urandom; b = $urandom;
      model(T_MULT, a, b, eh, el);
      @(posedge clk); #1;
      start = 1'b1; op = T_MULT; src1 = a; src2 = b;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         start = (c >= 5 && c < 25);
         op = T_DIVU; src1 = $urandom; src2 = 32'd0;
         @(negedge clk);
         if (hi_we || lo_we) begin lat = c; break; end
      end
      n_checks++;
      if (lat != 33 || hi_i !== eh || lo_i !== el) begin
         n_fail++; $display("FAIL start_while_busy got lat=%0d hi=%h lo=%h exp lat=33 hi=%h lo=%h", lat, hi_i, lo_i, eh, el);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL start_busy_idle got busy=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mt();
      test_cancel();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
